// File: rtl/inc_share_arbiter_pkg.sv
// inc_share_arbiter shared types: FSM state, default sizes,
// and the round-robin pointer helper.
package inc_share_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 4;

    // Pointer moves to the requester just after the winner.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/inc_share_arbiter_if.sv
// Requester/response bundle for inc_share_arbiter.
// master: producers + consumer; slave: the arbiter.
interface inc_share_arbiter_if
    import inc_share_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [WIDTH-1:0]      resp_sum;
    logic                  resp_carry;

    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_id,
        input  resp_sum, resp_carry
    );

    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_id,
        output resp_sum, resp_carry
    );

endinterface

// File: rtl/inc_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// req/ptr/en in; one-hot grant (gated by en) and winner idx out.
module rr_arbiter
    import inc_share_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic found;
    int   c;

    // Scan ascending from ptr with wrap; first set bit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < NREQ; k++) begin
            c = (int'(ptr) + k) % NREQ;
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = IDW'(c);
            end
        end
        if (found && en)
            grant[idx] = 1'b1;
    end

endmodule

// File: rtl/inc_share_arbiter.sv
// Shares one incrementer among NREQ requesters, one-entry result buffer.
// Ports: clk, rst (async high), bus (slave). Macro: INC_SHARE_ARBITER_SATURATE_EN.
module inc_share_arbiter
    import inc_share_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input logic                 clk,
    input logic                 rst,
    inc_share_arbiter_if.slave  bus
);

    localparam int IDW = $clog2(NREQ);

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   win;
    logic [NREQ-1:0]  grant;
    logic             acc;
    logic             fire;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   inc;
    logic [WIDTH-1:0] sum_d;
    logic             carry_d;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    // Buffer can take a new result if empty or being drained now.
    assign acc = (state_q == EMPTY) | bus.resp_ready;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .en    (acc & ~rst),
        .grant (grant),
        .idx   (win)
    );

    assign bus.req_ready = grant;
    assign fire          = |grant;

    // Only the winner's lane reaches the adder.
    assign opnd = bus.req_data[win*WIDTH +: WIDTH];
    assign inc  = {1'b0, opnd} + (WIDTH+1)'(1);

`ifdef INC_SHARE_ARBITER_SATURATE_EN
    assign sum_d = inc[WIDTH] ? {WIDTH{1'b1}} : inc[WIDTH-1:0];
`else
    assign sum_d = inc[WIDTH-1:0];
`endif
    assign carry_d = inc[WIDTH];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (fire) state_d = FULL;
            FULL: begin
                if (fire)
                    state_d = FULL;
                else if (bus.resp_ready)
                    state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            rr_ptr  <= '0;
            id_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                id_q    <= win;
                sum_q   <= sum_d;
                carry_q <= carry_d;
                rr_ptr  <= IDW'(rr_next(int'(win), NREQ));
            end
        end
    end

    assign bus.resp_valid = (state_q == FULL);
    assign bus.resp_id    = id_q;
    assign bus.resp_sum   = sum_q;
    assign bus.resp_carry = carry_q;

endmodule

// File: tb/tb_inc_share_arbiter.sv
// Self-checking bench for inc_share_arbiter.
// Scenario tasks plus a randomized run against a queue-free buffer model.
module tb_inc_share_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inc_share_arbiter_if #(.NREQ(N), .WIDTH(W)) bus();

    inc_share_arbiter #(.NREQ(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model of the buffer and pointer, derived from the arbitration rules.
    int m_ptr;
    bit m_full;
    int m_id;
    int m_sum;
    int m_carry;
    int ops [N];

    function automatic int exp_sum(input int op);
        int v;
        v = op + 1;
`ifdef INC_SHARE_ARBITER_SATURATE_EN
        if (v == 16) return 15;
`endif
        return v % 16;
    endfunction

    function automatic int exp_carry(input int op);
        return (op == 15) ? 1 : 0;
    endfunction

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g;
        int c;
        g = '0;
        if (rst) return g;
        if (m_full && !bus.resp_ready) return g;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (bus.req_valid[c]) begin
                g[c] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_full = 0; m_id = 0; m_sum = 0; m_carry = 0;
    endtask

    // Non-requesting lanes are driven to X.
    task automatic apply(input logic [N-1:0] v, input int d [N], input logic rr);
        bus.req_valid  = v;
        bus.resp_ready = rr;
        for (int i = 0; i < N; i++) begin
            ops[i] = d[i];
            bus.req_data[i*W +: W] = v[i] ? W'(d[i]) : 'x;
        end
        #1;
    endtask

    task automatic tick();
        logic [N-1:0] g;
        logic rr;
        g  = exp_grant();
        rr = bus.resp_ready;
        @(posedge clk);
        #1;
        if (g != '0) begin
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    m_id    = i;
                    m_sum   = exp_sum(ops[i]);
                    m_carry = exp_carry(ops[i]);
                    m_full  = 1;
                    m_ptr   = (i + 1) % N;
                end
            end
        end else if (rr) begin
            m_full = 0;
        end
    endtask

    task automatic test_reset();
        int d [N] = '{1, 2, 3, 4};
        rst = 1'b1;
        model_reset();
        apply(4'b1111, d, 1'b1);
        total++;
        if (bus.req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_req_ready got=%b want=0000", bus.req_ready);
        end
        total++;
        if ({bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_carry} !== '0) begin
            bad++;
            $display("FAIL reset_resp got=%b/%0d/%0d/%b want=0/0/0/0",
                     bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_carry);
        end
        @(negedge clk);
        rst = 1'b0;
        apply(4'b0000, d, 1'b1);
    endtask

    task automatic test_single();
        int d [N] = '{0, 0, 3, 0};
        apply(4'b0100, d, 1'b1);
        total++;
        if (bus.req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL single_grant got=%b want=0100", bus.req_ready);
        end
        tick();
        apply(4'b0000, d, 1'b1);
        total++;
        if (bus.req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL single_grant_once got=%b want=0000", bus.req_ready);
        end
        total++;
        if ({bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_carry} !==
            {1'b1, 2'd2, 4'b0100, 1'b0}) begin
            bad++;
            $display("FAIL single_resp got=%b/%0d/%b/%b want=1/2/0100/0",
                     bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_carry);
        end
        tick();
        total++;
        if (bus.resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drain got=%b want=0", bus.resp_valid);
        end
    endtask

    task automatic test_wrap();
        int d [N] = '{15, 0, 0, 0};
        logic [W-1:0] want;
`ifdef INC_SHARE_ARBITER_SATURATE_EN
        want = 4'b1111;
`else
        want = 4'b0000;
`endif
        apply(4'b0001, d, 1'b1);
        tick();
        apply(4'b0000, d, 1'b1);
        total++;
        if ({bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_carry} !==
            {1'b1, 2'd0, want, 1'b1}) begin
            bad++;
            $display("FAIL wrap got=%b/%0d/%b/%b want=1/0/%b/1",
                     bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_carry, want);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int d [N] = '{7, 2, 5, 9};
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 8; k++) begin
            apply(4'b1111, d, 1'b1);
            total++;
            if (bus.req_ready !== 4'(1 << (k % N))) begin
                bad++;
                $display("FAIL rr_grant[%0d] got=%b want=%b", k, bus.req_ready, 4'(1 << (k % N)));
            end
            tick();
            total++;
            if (!bus.resp_valid || bus.resp_id !== 2'(k % N) ||
                bus.resp_sum !== 4'(d[k % N] + 1)) begin
                bad++;
                $display("FAIL rr_resp[%0d] got=%b/%0d/%0d want=1/%0d/%0d",
                         k, bus.resp_valid, bus.resp_id, bus.resp_sum, k % N, d[k % N] + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int d [N] = '{4, 8, 1, 12};
        for (int k = 0; k < 5; k++) begin
            apply(4'b1111, d, 1'b0);
            total++;
            if (bus.req_ready !== 4'b0000) begin
                bad++;
                $display("FAIL bp_ready[%0d] got=%b want=0000", k, bus.req_ready);
            end
            tick();
            total++;
            if ({bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_carry} !==
                {1'b1, 2'(m_id), 4'(m_sum), 1'(m_carry)}) begin
                bad++;
                $display("FAIL bp_hold[%0d] got=%b/%0d/%0d/%b want=1/%0d/%0d/%0d",
                         k, bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_carry,
                         m_id, m_sum, m_carry);
            end
        end
        apply(4'b1111, d, 1'b1);
        total++;
        if (bus.req_ready !== 4'(1 << ((m_id + 1) % N))) begin
            bad++;
            $display("FAIL bp_release got=%b want=%b", bus.req_ready, 4'(1 << ((m_id + 1) % N)));
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        int d [N] = '{6, 6, 6, 6};
        apply(4'b1111, d, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (bus.resp_valid !== 1'b0 || bus.resp_sum !== 4'b0000) begin
            bad++;
            $display("FAIL midstall_rst got=%b/%b want=0/0000", bus.resp_valid, bus.resp_sum);
        end
        @(negedge clk);
        rst = 1'b0;
        apply(4'b1111, d, 1'b1);
        total++;
        if (bus.req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL midstall_first got=%b want=0001", bus.req_ready);
        end
        tick();
    endtask

    task automatic test_sweep();
        int d [N];
        for (int op = 0; op < 16; op++) begin
            d = '{0, op, 0, 0};
            apply(4'b0010, d, 1'b1);
            tick();
            total++;
            if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd1 ||
                bus.resp_sum !== 4'(exp_sum(op)) || bus.resp_carry !== 1'(exp_carry(op))) begin
                bad++;
                $display("FAIL sweep[%0d] got=%b/%0d/%0d/%b want=1/1/%0d/%0d",
                         op, bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_carry,
                         exp_sum(op), exp_carry(op));
            end
        end
    endtask

    task automatic test_random();
        int d [N];
        logic [N-1:0] v;
        logic rr;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) d[i] = int'($urandom_range(0, 15));
            v  = N'($urandom);
            rr = ($urandom_range(0, 3) != 0);
            apply(v, d, rr);
            total++;
            if (bus.req_ready !== exp_grant()) begin
                bad++;
                $display("FAIL rand_grant[%0d] got=%b want=%b", k, bus.req_ready, exp_grant());
            end
            tick();
            total++;
            if (bus.resp_valid !== 1'(m_full) ||
                (m_full && (bus.resp_id !== 2'(m_id) || bus.resp_sum !== 4'(m_sum) ||
                            bus.resp_carry !== 1'(m_carry)))) begin
                bad++;
                $display("FAIL rand_resp[%0d] got=%b/%0d/%0d/%b want=%0d/%0d/%0d/%0d",
                         k, bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_carry,
                         m_full, m_id, m_sum, m_carry);
            end
        end
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.resp_ready = 1'b0;
        #2;
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_backpressure();
        test_reset_mid_stall();
        test_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inc_share_arbiter.md
# inc_share_arbiter

Shares one WIDTH-bit incrementer (sum = A + 1, carry-out) between NREQ requesters. Round-robin arbitration selects one requester per accepted cycle. The selected operand goes through the single incrementer, and the result is registered in a one-entry output buffer with a valid/ready handshake. The block sits between the operand producers and the shared incrementer datapath and owns all sequencing of that datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 4, operand/sum width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  bit i: requester i has an operand
- req_data  in  NREQ*WIDTH  operand of requester i in bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot or zero; bit i high: operand i taken this cycle
- resp_valid  out  1  result buffer full
- resp_ready  in  1  consumer takes result
- resp_id  out  $clog2(NREQ)  index of the requester that produced the result
- resp_sum  out  WIDTH  incremented operand
- resp_carry  out  1  carry-out of the increment

## Operation
- Two-state Moore FSM:
  - EMPTY: resp_valid=0.
  - FULL: resp_valid=1.
- Accept condition: acc = (state==EMPTY) | resp_ready.
- Grant:
  - Scan req_valid starting at rr_ptr, ascending, wrapping at NREQ-1 → 0.
  - The first set bit wins.
  - req_ready = onehot(winner) & {NREQ{acc}}. Combinational from req_valid, rr_ptr and state/resp_ready.
- Transfer: a grant fires when req_valid[i] & req_ready[i]. On the next edge:
  - resp_sum, resp_carry ← {carry,sum} = req_data[i] + 1.
  - resp_id ← i.
  - state ← FULL.
  - rr_ptr ← (i+1) mod NREQ.
- Drain:
  - FULL & resp_ready & no request → EMPTY.
  - FULL & resp_ready & a request present → stays FULL with the new result. Back-to-back, one result per cycle.
- Stall: FULL & !resp_ready → req_ready=0. resp_* held bit-stable. rr_ptr unchanged.
- rr_ptr advances only on a grant, never on idle cycles.
- Arithmetic: WIDTH+1-bit add.
  - All-ones operand → sum 0, carry 1.
  - Any other operand → carry 0.
- Reset (asynchronous, any time including mid-stall): state=EMPTY, resp_valid=0, resp_id=0, resp_sum=0, resp_carry=0, rr_ptr=0. Any pending result is discarded. req_ready is 0 while rst is high.
- X on req_data of non-granted requesters must not propagate to outputs.

## Timing
- Latency: operand accepted at edge N → result valid after edge N (visible in cycle N+1).
- Throughput: 1 result/cycle while resp_ready=1.
- Fairness: with all requesters continuously valid, each is granted exactly once every NREQ grants.
- Simultaneous drain and accept in the same cycle is legal and loses no data.
- No combinational path from resp_ready to resp_*. resp_ready → req_ready is combinational.

## Configuration
- INC_SHARE_ARBITER_SATURATE_EN defined:
  - All-ones operand produces resp_sum = all-ones (saturated) and resp_carry=1 (overflow flag).
  - Other operands are unchanged.
- Undefined: wrap-around behaviour, sum 0 with carry 1.
- Handshake and timing are identical in both builds.

## Structure
- Package inc_share_pkg:
  - FSM state enum {EMPTY, FULL}.
  - Default WIDTH/NREQ constants.
  - Function for the next round-robin pointer.
- Sub-module rr_arbiter (NREQ): inputs req, ptr, en; output one-hot grant and winner index. Purely combinational.
- Top holds the FSM, rr_ptr register, incrementer expression and output buffer.

## Test plan
- Reset then single request: req_valid=4'b0100, req_data[11:8]=4'b0011, resp_ready=1 → req_ready=4'b0100 for one cycle. Next cycle: resp_valid=1, resp_id=2, resp_sum=4'b0100, resp_carry=0.
- Wrap: requester 0 operand 4'b1111 → resp_sum=0, resp_carry=1. With INC_SHARE_ARBITER_SATURATE_EN: resp_sum=4'b1111, resp_carry=1.
- Round-robin: all four valid, resp_ready=1, 8 cycles → resp_id sequence 0,1,2,3,0,1,2,3. No bubbles.
- Backpressure: resp_ready=0 for 5 cycles with requests pending → req_ready=0 and resp_* stable throughout. On release, the next grant goes to the next requester after the held resp_id.
- Reset mid-stall: assert rst asynchronously between edges while FULL → resp_valid=0 and resp_sum=0 immediately, before the next edge. After release, the first grant goes to requester 0 when all are valid.
- Operand sweep: requester 1 presents 0..15 on successive accepted cycles → resp_sum = operand+1 mod 16; resp_carry=1 only for operand 15.
